traffic_signal_ctrl: RTL and testbench

Parametrised highway/country-road intersection controller; next generation of the two-road signal controller. Drives 2-bit lamp codes for the highway (`hw`) and the country road (`cw`) from a country-road vehicle sensor. Adds programmable phase durations, a minimum highway green, a maximum country green with timeout, all-red clearance intervals, and a highway-priority override input. Sits between the sensor front end and the lamp drivers.

---
 rtl/traffic_signal_ctrl_pkg.sv | 18 +
 rtl/traffic_signal_ctrl_phase_timer.sv | 22 ++
 rtl/traffic_signal_ctrl.sv | 79 +++++++
 tb/tb_traffic_signal_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_signal_ctrl_pkg.sv
// Shared definitions for the highway/country-road intersection controller:
// state codes and lamp encodings used by the controller and its environment.
package traffic_signal_ctrl_pkg;

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        AR_TO_CW  = 3'd2,
        CW_GREEN  = 3'd3,
        CW_YELLOW = 3'd4,
        AR_TO_HW  = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

endpackage

// File: rtl/traffic_signal_ctrl_phase_timer.sv
// Phase timer: saturating up-counter with synchronous clear, measuring how
// long the controller has been in its current state.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_signal_ctrl.sv
// Highway/country-road signal controller: Moore FSM with programmable phase
// durations, minimum highway green, country-green timeout and override.
module traffic_signal_ctrl
    import traffic_signal_ctrl_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int YELLOW_CYC   = 3,
    parameter int ALLRED_CYC   = 2,
    parameter int HW_MIN_GREEN = 8,
    parameter int CW_MAX_GREEN = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       force_hw,
    output logic [1:0] hw,
    output logic [1:0] cw,
    output logic [2:0] phase
);

    // Timer is 0 in the first cycle of a state, so each limit compares against N-1.
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] HW_MIN_LAST = CNT_W'(HW_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CW_MAX_LAST = CNT_W'(CW_MAX_GREEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic             timer_clr;

    phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .count (timer)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HW_GREEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HW_GREEN:  if (x && !force_hw && timer >= HW_MIN_LAST) state_next = HW_YELLOW;
            HW_YELLOW: if (timer == YELLOW_LAST) state_next = AR_TO_CW;
            AR_TO_CW:  if (timer == ALLRED_LAST) state_next = CW_GREEN;
            CW_GREEN:  if (!x || force_hw || timer == CW_MAX_LAST) state_next = CW_YELLOW;
            CW_YELLOW: if (timer == YELLOW_LAST) state_next = AR_TO_HW;
            AR_TO_HW:  if (timer == ALLRED_LAST) state_next = HW_GREEN;
            default:   state_next = HW_GREEN;
        endcase
    end

    assign timer_clr = (state_next != state);

    // Lamps decode the registered state only; no input reaches them combinationally.
    always_comb begin
        hw    = LAMP_RED;
        cw    = LAMP_RED;
        phase = state;
        case (state)
            HW_GREEN:  hw = LAMP_GREEN;
            HW_YELLOW: hw = LAMP_YELLOW;
            CW_GREEN:  cw = LAMP_GREEN;
            CW_YELLOW: cw = LAMP_YELLOW;
            default: begin
                hw = LAMP_RED;
                cw = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// Bench for traffic_signal_ctrl: directed timing scenarios plus randomized
// sensor/override traffic checked against a phase-level reference model.
module tb_traffic_signal_ctrl;

    localparam int YEL    = 3;
    localparam int AR     = 2;
    localparam int HW_MIN = 8;
    localparam int CW_MAX = 10;
    localparam logic [6:0] RST_EXP = {3'd0, 2'd2, 2'd0};

    logic       clk;
    logic       reset;
    logic       x;
    logic       force_hw;
    logic [1:0] hw;
    logic [1:0] cw;
    logic [2:0] phase;

    traffic_signal_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .force_hw (force_hw),
        .hw       (hw),
        .cw       (cw),
        .phase    (phase)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [6:0] exp_q[$];
    int total;
    int passed;
    int fails;
    int cyc;
    int ph_log[256];

    // reference model: phase index 0..5 in road order, and cycles spent in it
    int m_ph;
    int m_age;

    function automatic logic [6:0] model_out(input int ph);
        logic [1:0] h;
        logic [1:0] c;
        h = 2'd0;
        c = 2'd0;
        if (ph == 0) h = 2'd2;
        if (ph == 1) h = 2'd1;
        if (ph == 3) c = 2'd2;
        if (ph == 4) c = 2'd1;
        return {3'(ph), h, c};
    endfunction

    task automatic model_reset();
        m_ph  = 0;
        m_age = 0;
        exp_q.delete();
        exp_q.push_back(model_out(0));
    endtask

    task automatic model_step(input logic xi, input logic fi);
        bit leave;
        case (m_ph)
            0:       leave = xi && !fi && (m_age + 1 >= HW_MIN);
            3:       leave = !xi || fi || (m_age + 1 == CW_MAX);
            1, 4:    leave = (m_age + 1 == YEL);
            default: leave = (m_age + 1 == AR);
        endcase
        if (leave) begin
            m_ph  = (m_ph + 1) % 6;
            m_age = 0;
        end else begin
            m_age++;
        end
        exp_q.push_back(model_out(m_ph));
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // driver tasks: called at a negedge; check current outputs, apply inputs, step a cycle
    task automatic run_cycle(input logic xi, input logic fi);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            e = 7'h7f;
        end else begin
            e = exp_q.pop_front();
        end
        chk("model", {phase, hw, cw}, e);
        chk("exclusive", 7'(hw != 2'd0 && cw != 2'd0), 7'd0);
        if (cyc < 256) ph_log[cyc] = int'(phase);
        x = xi;
        force_hw = fi;
        @(posedge clk);
        model_step(xi, fi);
        @(negedge clk);
        cyc++;
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("in_reset", {phase, hw, cw}, RST_EXP);
            @(negedge clk);
        end
        reset = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        cyc    = 0;
        reset  = 1'b0;
        x      = 1'b0;
        force_hw = 1'b0;
        @(negedge clk);

        // 1: long reset then idle road
        hold_reset(20);
        for (int i = 0; i < 50; i++) run_cycle(1'b0, 1'b0);
        chk("s1_idle_phase", 7'(phase), 7'd0);

        // 2: continuous demand, country green times out
        hold_reset(2);
        for (int i = 0; i < 40; i++) run_cycle(1'b1, 1'b0);
        chk("s2_hwg7",  7'(ph_log[7]),  7'd0);
        chk("s2_hwy8",  7'(ph_log[8]),  7'd1);
        chk("s2_ar11",  7'(ph_log[11]), 7'd2);
        chk("s2_cwg13", 7'(ph_log[13]), 7'd3);
        chk("s2_cwg22", 7'(ph_log[22]), 7'd3);
        chk("s2_cwy23", 7'(ph_log[23]), 7'd4);
        chk("s2_ar26",  7'(ph_log[26]), 7'd5);
        chk("s2_hwg28", 7'(ph_log[28]), 7'd0);
        chk("s2_hwg35", 7'(ph_log[35]), 7'd0);
        chk("s2_hwy36", 7'(ph_log[36]), 7'd1);

        // 3: late demand, min green already satisfied
        hold_reset(2);
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        chk("s3_hwg20", 7'(ph_log[20]), 7'd0);
        chk("s3_hwy21", 7'(ph_log[21]), 7'd1);

        // 4: car leaves during country green
        hold_reset(2);
        for (int i = 0; i < 17; i++) run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);
        chk("s4_cwg17", 7'(ph_log[17]), 7'd3);
        chk("s4_cwy18", 7'(ph_log[18]), 7'd4);

        // 5: override during country green, then held and released
        hold_reset(2);
        for (int i = 0; i < 15; i++) run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0);
        chk("s5_cwy16", 7'(ph_log[16]), 7'd4);
        chk("s5_hwg21", 7'(ph_log[21]), 7'd0);
        chk("s5_hold30", 7'(ph_log[30]), 7'd0);
        chk("s5_hwg31", 7'(ph_log[31]), 7'd0);
        chk("s5_hwy32", 7'(ph_log[32]), 7'd1);

        // 6: asynchronous reset in the middle of country yellow
        hold_reset(2);
        for (int i = 0; i < 24; i++) run_cycle(1'b1, 1'b0);
        chk("s6_pre_cwy", {phase, hw, cw}, {3'd4, 2'd0, 2'd1});
        #2;
        reset = 1'b0;
        #1;
        chk("s6_async", {phase, hw, cw}, RST_EXP);
        @(negedge clk);
        hold_reset(3);
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 1'b0);
        chk("s6_hwy8",  7'(ph_log[8]),  7'd1);
        chk("s6_cwg13", 7'(ph_log[13]), 7'd3);
        chk("s6_cwy23", 7'(ph_log[23]), 7'd4);
        chk("s6_hwg28", 7'(ph_log[28]), 7'd0);

        // randomized traffic against the model
        hold_reset(2);
        for (int i = 0; i < 800; i++) begin
            run_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
